// File: rtl/host_cmd_rx_if.sv
// Host command receive bus: byte stream in from avr_interface, decoded
// commands and error/status out toward the board/flag logic.
interface host_cmd_rx_if #(
  parameter int unsigned MAX_LEN = 8
) ();
  logic [7:0]           rx_data;
  logic                 new_rx_data;
  logic                 cmd_ready;
  logic                 cmd_valid;
  logic [7:0]           cmd_id;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_chk;
  logic                 err_len;
  logic                 err_timeout;
  logic                 err_overrun;
  logic [15:0]          frame_cnt;

  // Byte source and command consumer side
  modport master (
    output rx_data, new_rx_data, cmd_ready,
    input  cmd_valid, cmd_id, cmd_len, cmd_payload,
    input  err_chk, err_len, err_timeout, err_overrun, frame_cnt
  );

  // Decoder side
  modport slave (
    input  rx_data, new_rx_data, cmd_ready,
    output cmd_valid, cmd_id, cmd_len, cmd_payload,
    output err_chk, err_len, err_timeout, err_overrun, frame_cnt
  );
endinterface

// File: rtl/host_cmd_rx.sv
// Receive-side command decoder for the AVR serial link.
// Frames SYNC,CMD,LEN,PAYLOAD[LEN],CHK with an XOR checksum over CMD..PAYLOAD,
// hands good commands out on a valid/ready port, and flags frame errors.
module host_cmd_rx #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_LEN     = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  host_cmd_rx_if.slave bus
);

  localparam int unsigned GW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam int unsigned PW        = 8 * MAX_LEN;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [7:0]      id_q, id_d;
  logic [3:0]      slen_q, slen_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic            good_q, good_d;

  logic            cmd_valid_q, cmd_valid_d;
  logic [7:0]      cmd_id_q, cmd_id_d;
  logic [3:0]      cmd_len_q, cmd_len_d;
  logic [PW-1:0]   cmd_payload_q, cmd_payload_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            err_chk_q, err_chk_d;
  logic            err_len_q, err_len_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;

  logic            timeout;

  // A byte landing on the expiry cycle wins over the timeout.
  assign timeout = (state_q != S_HUNT) && !bus.new_rx_data && (gap_q == GAP_LAST);

  // Frame FSM, gap timer, shadow buffer and delivery next-state logic
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    id_d          = id_q;
    slen_d        = slen_q;
    idx_d         = idx_q;
    chk_d         = chk_q;
    shadow_d      = shadow_q;
    good_d        = 1'b0;
    cmd_valid_d   = cmd_valid_q;
    cmd_id_d      = cmd_id_q;
    cmd_len_d     = cmd_len_q;
    cmd_payload_d = cmd_payload_q;
    frame_cnt_d   = frame_cnt_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    if (bus.new_rx_data || state_q == S_HUNT) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + 1'b1;
    end

    if (timeout) begin
      state_d       = S_HUNT;
      err_timeout_d = 1'b1;
      gap_d         = '0;
    end else if (bus.new_rx_data) begin
      unique case (state_q)
        S_HUNT: begin
          if (bus.rx_data == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          id_d    = bus.rx_data;
          chk_d   = bus.rx_data;
          state_d = S_LEN;
        end
        S_LEN: begin
          if (bus.rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            chk_d    = chk_q ^ bus.rx_data;
            slen_d   = bus.rx_data[3:0];
            idx_d    = '0;
            shadow_d = '0;
            state_d  = (bus.rx_data == 8'd0) ? S_CHK : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (idx_q == 4'(i)) shadow_d[8*i +: 8] = bus.rx_data;
          end
          chk_d = chk_q ^ bus.rx_data;
          idx_d = idx_q + 4'd1;
          if (idx_q == slen_q - 4'd1) state_d = S_CHK;
        end
        S_CHK: begin
          if (bus.rx_data == chk_q) good_d = 1'b1;
          else                      err_chk_d = 1'b1;
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end

    // Delivery runs one edge behind the CHK byte; the shadow buffer cannot
    // be touched again before then because the next frame needs SYNC first.
    if (good_q) begin
      if (cmd_valid_q && !bus.cmd_ready) begin
        err_overrun_d = 1'b1;
      end else begin
        cmd_valid_d   = 1'b1;
        cmd_id_d      = id_q;
        cmd_len_d     = slen_q;
        cmd_payload_d = shadow_q;
        frame_cnt_d   = frame_cnt_q + 16'd1;
      end
    end else if (cmd_valid_q && bus.cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HUNT;
      gap_q         <= '0;
      id_q          <= '0;
      slen_q        <= '0;
      idx_q         <= '0;
      chk_q         <= '0;
      shadow_q      <= '0;
      good_q        <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_id_q      <= '0;
      cmd_len_q     <= '0;
      cmd_payload_q <= '0;
      frame_cnt_q   <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      id_q          <= id_d;
      slen_q        <= slen_d;
      idx_q         <= idx_d;
      chk_q         <= chk_d;
      shadow_q      <= shadow_d;
      good_q        <= good_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_id_q      <= cmd_id_d;
      cmd_len_q     <= cmd_len_d;
      cmd_payload_q <= cmd_payload_d;
      frame_cnt_q   <= frame_cnt_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_id      = cmd_id_q;
  assign bus.cmd_len     = cmd_len_q;
  assign bus.cmd_payload = cmd_payload_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_len     = err_len_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule
